// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_timer_pkg;

    // Default counter / load-value width in bits.
    localparam int unsigned CdDefaultWidth = 4;

    // Controller states: waiting for a load, or counting down.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } cd_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered
// single-cycle terminal-count pulse.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = CdDefaultWidth
) (
    input  logic             ClkIn,
    input  logic             Rst,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Enable,
    input  logic             Stop,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done
);

    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    cd_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Next-state decode, priority Load > Stop > decrement > hold.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (Load) begin
            if (LoadValue != '0) begin
                count_d  = LoadValue;
                reload_d = LoadValue;
                state_d  = StRun;
            end else begin
                // A zero load terminates immediately.
                count_d = '0;
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end else if (Stop) begin
            state_d = StIdle;
        end else if (state_q == StRun && Enable) begin
            if (count_q == CountOne) begin
                done_d = 1'b1;
                if (AutoReload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = StIdle;
                end
            end else if (count_q > CountOne) begin
                count_d = count_q - CountOne;
            end
            // count_q == 0 in RUN is unreachable; hold rather than wrap.
        end

        busy_d = (state_d == StRun);
    end

    // All state and registered outputs, async active-low reset.
    always_ff @(posedge ClkIn or negedge Rst) begin
        if (!Rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign Count = count_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule
